// File: rtl/hpsfpga_led_sequencer.sv
// LED pattern sequencer: a small register slave configures patterns and timing,
// and a master port pushes one LED value at a time to the PIO.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | sequence stopped, master port quiet
//  WRITE | master write in flight, held until the interconnect accepts it
//  WAIT  | inter-step delay, down-counter runs to terminal count 0
//  NEXT  | advance the pattern index / rotation, decide wrap or finish
module hpsfpga_led_sequencer #(
    parameter int          LED_WIDTH  = 10,
    parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    localparam logic [3:0] STEP_LAST = 4'(LED_WIDTH - 1);

    state_t                state, state_nxt;
    logic                  en, mode, oneshot, done;
    logic [31:0]           period;
    logic [2:0]            count;
    logic [LED_WIDTH-1:0]  pat [4];
    logic [1:0]            idx, idx_nxt;
    logic [3:0]            step, step_nxt;
    logic [LED_WIDTH-1:0]  rot, rot_nxt, rot_left;
    logic [31:0]           timer, timer_nxt, period_load;
    logic [2:0]            count_eff;
    logic [1:0]            last_idx;
    logic                  last_step, finish;
    logic                  wr_any, wr_ctrl, wr_period, wr_count, wr_status, wr_pat;
    logic                  en_eff, mode_eff;
    logic [LED_WIDTH-1:0]  led_nxt;

    assign wr_any    = chipselect & ~write_n;
    assign wr_ctrl   = wr_any & (address == 3'd0);
    assign wr_period = wr_any & (address == 3'd1);
    assign wr_count  = wr_any & (address == 3'd2);
    assign wr_status = wr_any & (address == 3'd3);
    assign wr_pat    = wr_any & address[2];

    // A CTRL write in the current cycle is seen by the FSM immediately
    assign en_eff   = wr_ctrl ? writedata[0] : en;
    assign mode_eff = wr_ctrl ? writedata[1] : mode;

    assign count_eff   = (count == 3'd0) ? 3'd1 : ((count > 3'd4) ? 3'd4 : count);
    assign last_idx    = 2'(count_eff - 3'd1);
    assign last_step   = mode ? (step >= STEP_LAST) : (idx == last_idx);
    assign period_load = (period == 32'd0) ? 32'd0 : (period - 32'd1);
    assign rot_left    = {rot[LED_WIDTH-2:0], rot[LED_WIDTH-1]};

    assign m_address = 2'b00;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        step_nxt  = step;
        rot_nxt   = rot;
        timer_nxt = timer;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ctrl && writedata[0]) begin
                    state_nxt = WRITE;
                    idx_nxt   = 2'd0;
                    step_nxt  = 4'd0;
                    rot_nxt   = pat[0];
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    if (en_eff) begin
                        state_nxt = WAIT;
                        timer_nxt = period_load;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT: begin
                if (!en_eff) begin
                    state_nxt = IDLE;
                end else if (timer == 32'd0) begin
                    state_nxt = NEXT;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            NEXT: begin
                if (!en_eff) begin
                    state_nxt = IDLE;
                end else if (last_step && oneshot) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = WRITE;
                    if (mode) begin
                        rot_nxt  = rot_left;
                        step_nxt = last_step ? 4'd0 : 4'(step + 4'd1);
                    end else begin
                        idx_nxt  = last_step ? 2'd0 : 2'(idx + 2'd1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign led_nxt = mode_eff ? rot_nxt : pat[idx_nxt];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= 2'd0;
            step         <= 4'd0;
            rot          <= '0;
            timer        <= 32'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 32'd0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            step         <= step_nxt;
            rot          <= rot_nxt;
            timer        <= timer_nxt;
            m_chipselect <= (state_nxt == WRITE);
            m_write_n    <= (state_nxt != WRITE);
            // Data is captured once on WRITE entry so it stays stable through stalls
            if (state_nxt == WRITE && state != WRITE) begin
                m_writedata <= {{(32-LED_WIDTH){1'b0}}, led_nxt};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b0;
            mode    <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b0;
            period  <= PERIOD_RST;
            count   <= 3'd1;
            for (int i = 0; i < 4; i++) begin
                pat[i] <= '1;
            end
        end else begin
            if (wr_ctrl) begin
                mode    <= writedata[1];
                oneshot <= writedata[2];
            end
            if (finish) begin
                en <= 1'b0;
            end else if (wr_ctrl) begin
                en <= writedata[0];
            end
            if (finish) begin
                done <= 1'b1;
            end else if (wr_status && writedata[1]) begin
                done <= 1'b0;
            end
            if (wr_period) begin
                period <= writedata;
            end
            if (wr_count) begin
                count <= writedata[2:0];
            end
            if (wr_pat) begin
                pat[address[1:0]] <= writedata[LED_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = {29'd0, oneshot, mode, en};
            3'd1:    readdata = period;
            3'd2:    readdata = {29'd0, count};
            3'd3:    readdata = {26'd0, idx, 2'b00, done, (state != IDLE)};
            default: readdata = {{(32-LED_WIDTH){1'b0}}, pat[address[1:0]]};
        endcase
    end

endmodule
